// File: rtl/module_control_pkg.sv
// Shared types and the module-select address decode used by the selector and its decoder.
package module_control_pkg;

  localparam int DATA_W            = 32;
  localparam int DEFAULT_N_MODULES = 4;
  localparam int DEFAULT_ADDR_W    = 3;

  // Widest module-select field the decode function accepts; narrower fields are zero-extended.
  localparam int MAX_ADDR_W = 8;

  typedef logic [MAX_ADDR_W-1:0] sel_addr_t;

  typedef struct packed {
    logic      valid;
    sel_addr_t index;
  } sel_t;

  // Address 0 is unmapped; address k in 1..n_modules selects module k-1.
  function automatic sel_t decode_addr(input sel_addr_t addr, input int unsigned n_modules);
    sel_t sel;
    sel.valid = (addr != '0) && (32'(addr) <= n_modules);
    sel.index = sel.valid ? (addr - sel_addr_t'(1)) : '0;
    return sel;
  endfunction

endpackage

// File: rtl/module_control_sel_decoder.sv
// Module-select decoder: turns the address field into a valid bit, a module index and
// a one-hot write strobe vector. Purely combinational.
module module_sel_decoder
  import module_control_pkg::*;
#(
  parameter int N_MODULES = DEFAULT_N_MODULES,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int IDX_W     = (N_MODULES > 1) ? $clog2(N_MODULES) : 1
) (
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic                 we_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     index_o,
  output logic [N_MODULES-1:0] module_we_o
);

  sel_t sel;

  assign sel     = decode_addr(sel_addr_t'(addr_i), N_MODULES);
  assign valid_o = sel.valid;
  assign index_o = sel.index[IDX_W-1:0];

  // NOTE: every always_comb output gets a default before any conditional assignment,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    module_we_o = '0;
    for (int k = 0; k < N_MODULES; k++) begin
      module_we_o[k] = we_i & sel.valid & (sel.index == sel_addr_t'(k));
    end
  end

endmodule

// File: rtl/module_control.sv
// Address-decoded selector: combinational read mux and write-strobe steering to N_MODULES
// user modules, plus clocked side-band tracking of the last write target and unmapped writes.
module module_control
  import module_control_pkg::*;
#(
  parameter int N_MODULES = DEFAULT_N_MODULES,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             we_i,
  input  logic [ADDR_W-1:0]                addr_i,
  input  logic [N_MODULES-1:0][DATA_W-1:0] module_data_i,
  output logic [DATA_W-1:0]                data_o,
  output logic [N_MODULES-1:0]             module_we_o,
  output logic                             sel_valid_o,
  output logic [ADDR_W-1:0]                last_sel_o,
  output logic                             bad_wr_o
);

  localparam int IDX_W = (N_MODULES > 1) ? $clog2(N_MODULES) : 1;

  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_index;
  logic [N_MODULES-1:0] rd_sel;

  module_sel_decoder #(
    .N_MODULES (N_MODULES),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W)
  ) u_decoder (
    .addr_i      (addr_i),
    .we_i        (we_i),
    .valid_o     (sel_valid),
    .index_o     (sel_index),
    .module_we_o (module_we_o)
  );

  assign sel_valid_o = sel_valid;

  // Read select ignores we_i so reads and writes present identical data.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_MODULES; k++) begin
      rd_sel[k] = sel_valid & (sel_index == IDX_W'(k));
    end
  end

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N_MODULES; k++) begin
      data_o = data_o | (module_data_i[k] & {DATA_W{rd_sel[k]}});
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples the
  // pre-edge values and simulation order between processes cannot change the result.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_sel_o <= '0;
      bad_wr_o   <= 1'b0;
    end else if (we_i) begin
      if (sel_valid) begin
        last_sel_o <= addr_i;
      end else begin
        bad_wr_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_module_control.sv
// Directed and randomised bench for module_control with the default 4-module configuration.
module tb_module_control;

  localparam int N = 4;
  localparam int AW = 3;
  localparam int DW = 32;

  logic                   wb_clk_i;
  logic                   wb_rst_i;
  logic                   we_i;
  logic [AW-1:0]          addr_i;
  logic [N-1:0][DW-1:0]   module_data_i;
  logic [DW-1:0]          data_o;
  logic [N-1:0]           module_we_o;
  logic                   sel_valid_o;
  logic [AW-1:0]          last_sel_o;
  logic                   bad_wr_o;

  int tests_run = 0;
  int tests_failed = 0;

  module_control #(.N_MODULES(N), .ADDR_W(AW)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .module_data_i (module_data_i),
    .data_o        (data_o),
    .module_we_o   (module_we_o),
    .sel_valid_o   (sel_valid_o),
    .last_sel_o    (last_sel_o),
    .bad_wr_o      (bad_wr_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge, sampled 1 time unit later.
  task automatic apply(input logic we, input logic [AW-1:0] addr);
    @(negedge wb_clk_i);
    we_i   = we;
    addr_i = addr;
    #1;
  endtask

  logic [DW-1:0] exp_data [0:4];
  logic [N-1:0]  exp_we;
  logic [DW-1:0] exp_d;
  logic          exp_v;
  logic [AW-1:0] m_last;
  logic          m_bad;
  logic [AW-1:0] r_addr;
  logic          r_we;

  initial begin
    wb_rst_i = 1'b1;
    we_i     = 1'b0;
    addr_i   = '0;
    module_data_i = {32'hFEEDC0DE, 32'hCAFEB0BA, 32'h8BADF00D, 32'hDEADBEEF};
    exp_data[0] = 32'h0;
    exp_data[1] = 32'hDEADBEEF;
    exp_data[2] = 32'h8BADF00D;
    exp_data[3] = 32'hCAFEB0BA;
    exp_data[4] = 32'hFEEDC0DE;

    repeat (2) @(posedge wb_clk_i);
    #1;
    check("reset_last_sel", 32'(last_sel_o), 32'd0);
    check("reset_bad_wr", 32'(bad_wr_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    apply(1'b0, 3'd0);
    check("rd_addr0_data", data_o, 32'h0);
    check("rd_addr0_we", 32'(module_we_o), 32'h0);
    check("rd_addr0_valid", 32'(sel_valid_o), 32'd0);

    for (int a = 1; a <= 4; a++) begin
      apply(1'b0, AW'(a));
      check($sformatf("rd_addr%0d_data", a), data_o, exp_data[a]);
      check($sformatf("rd_addr%0d_we", a), 32'(module_we_o), 32'h0);
      check($sformatf("rd_addr%0d_valid", a), 32'(sel_valid_o), 32'd1);
    end

    for (int a = 1; a <= 4; a++) begin
      apply(1'b1, AW'(a));
      check($sformatf("wr_addr%0d_data", a), data_o, exp_data[a]);
      check($sformatf("wr_addr%0d_we", a), 32'(module_we_o), 32'(1 << (a - 1)));
    end
    @(posedge wb_clk_i);
    #1;
    check("wr_last_sel_4", 32'(last_sel_o), 32'd4);
    check("wr_valid_no_bad", 32'(bad_wr_o), 32'd0);

    begin
      logic [AW-1:0] bad_addrs [0:3];
      bad_addrs[0] = 3'd0;
      bad_addrs[1] = 3'd5;
      bad_addrs[2] = 3'd6;
      bad_addrs[3] = 3'd7;
      for (int i = 0; i < 4; i++) begin
        apply(1'b1, bad_addrs[i]);
        check($sformatf("badwr_addr%0d_data", bad_addrs[i]), data_o, 32'h0);
        check($sformatf("badwr_addr%0d_we", bad_addrs[i]), 32'(module_we_o), 32'h0);
        check($sformatf("badwr_addr%0d_valid", bad_addrs[i]), 32'(sel_valid_o), 32'd0);
      end
    end
    @(posedge wb_clk_i);
    #1;
    check("bad_wr_set", 32'(bad_wr_o), 32'd1);
    check("bad_wr_keeps_last_sel", 32'(last_sel_o), 32'd4);

    apply(1'b1, 3'd3);
    @(posedge wb_clk_i);
    #1;
    check("last_sel_3", 32'(last_sel_o), 32'd3);
    check("bad_wr_sticky", 32'(bad_wr_o), 32'd1);

    apply(1'b0, 3'd2);
    @(posedge wb_clk_i);
    #1;
    check("read_holds_last_sel", 32'(last_sel_o), 32'd3);
    check("bad_wr_sticky_2", 32'(bad_wr_o), 32'd1);

    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    we_i     = 1'b1;
    addr_i   = 3'd2;
    #1;
    check("rst_comb_data", data_o, 32'h8BADF00D);
    check("rst_comb_we", 32'(module_we_o), 32'h2);
    check("rst_comb_valid", 32'(sel_valid_o), 32'd1);
    @(posedge wb_clk_i);
    #1;
    check("rst_beats_write_last_sel", 32'(last_sel_o), 32'd0);
    check("rst_clears_bad_wr", 32'(bad_wr_o), 32'd0);
    wb_rst_i = 1'b0;

    m_last = '0;
    m_bad  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < N; k++) module_data_i[k] = $urandom;
      r_addr = AW'($urandom_range(0, 7));
      r_we   = 1'($urandom_range(0, 1));
      apply(r_we, r_addr);
      check($sformatf("rnd%0d_last_sel", i), 32'(last_sel_o), 32'(m_last));
      check($sformatf("rnd%0d_bad_wr", i), 32'(bad_wr_o), 32'(m_bad));

      exp_v  = (r_addr >= 3'd1) && (r_addr <= 3'd4);
      exp_we = '0;
      exp_d  = '0;
      if (exp_v) begin
        exp_d = module_data_i[int'(r_addr) - 1];
        if (r_we) exp_we[int'(r_addr) - 1] = 1'b1;
      end
      check($sformatf("rnd%0d_data", i), data_o, exp_d);
      check($sformatf("rnd%0d_we", i), 32'(module_we_o), 32'(exp_we));
      check($sformatf("rnd%0d_valid", i), 32'(sel_valid_o), 32'(exp_v));
      check($sformatf("rnd%0d_onehot", i), 32'($countones(module_we_o) <= 1), 32'd1);

      if (r_we) begin
        if (exp_v) m_last = r_addr;
        else       m_bad  = 1'b1;
      end
    end
    @(posedge wb_clk_i);
    #1;
    check("rnd_final_last_sel", 32'(last_sel_o), 32'(m_last));
    check("rnd_final_bad_wr", 32'(bad_wr_o), 32'(m_bad));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/module_control.md
# module_control

Address-decoded module selector between the bus-side register interface and N_MODULES user modules. A small module-select address field routes one module's 32-bit read data to the shared read bus and steers the write-enable strobe to exactly that module. The data and strobe paths are purely combinational. A clocked side-band records the last valid selection and flags writes to unmapped addresses.

## Interface
- N_MODULES, 4, number of attached modules (1..7 with the default address width).
- ADDR_W, 3, module-select field width; must satisfy 2^ADDR_W > N_MODULES.
- DATA_W, 32, per-module data width.

Ports:
- wb_clk_i  in  1  single clock; used only by the side-band registers.
- wb_rst_i  in  1  reset, synchronous, active-high.
- we_i  in  1  write enable of the current access.
- addr_i  in  ADDR_W  module-select field; 0 is unmapped, k in 1..N_MODULES selects module k-1.
- module_data_i  in  N_MODULES x DATA_W (packed [N_MODULES-1:0][DATA_W-1:0])  read data from each module.
- data_o  out  DATA_W  selected module's read data.
- module_we_o  out  N_MODULES  one-hot write strobe per module.
- sel_valid_o  out  1  addr_i maps to a module (combinational).
- last_sel_o  out  ADDR_W  last valid addr_i seen while we_i=1 (registered).
- bad_wr_o  out  1  sticky flag: a write was attempted to an unmapped address (registered).

## Operation
- Valid address: 1 <= addr_i <= N_MODULES; index = addr_i - 1.
- Valid address: data_o = module_data_i[index]; sel_valid_o = 1.
- Invalid address (addr_i = 0 or addr_i > N_MODULES): data_o = 0, module_we_o = 0, sel_valid_o = 0.
- module_we_o[index] = we_i when the address is valid; every other bit is 0 in all cases.
- At most one module_we_o bit is ever high.
- data_o does not depend on we_i; reads and writes present the same data.
- Side-band, per clock edge:
  - wb_rst_i=1: last_sel_o <= 0, bad_wr_o <= 0.
  - Otherwise, if we_i=1 and the address is valid: last_sel_o <= addr_i.
  - Otherwise, if we_i=1 and the address is invalid: bad_wr_o <= 1 (sticky until reset).
- The side-band has no effect on data_o or module_we_o.

## Timing
- data_o, module_we_o and sel_valid_o are combinational from addr_i, we_i and module_data_i.
- These three outputs have zero latency and are valid within the same delta/cycle as their inputs.
- They are fully functional without a clock or reset. Reset does not gate them.
- Side-band outputs update one wb_clk_i edge after the qualifying inputs and are 0 after reset.
- Reset asserted mid-access:
  - The combinational paths continue to follow their inputs.
  - Only the side-band registers clear.
  - Reset takes priority over a same-cycle update.
- No handshake; callers hold addr_i and we_i stable for the bus cycle.

## Structure
- The shared package holds:
  - DATA_W and the default N_MODULES.
  - The address-to-index function: returns a valid bit and the index.
- One natural sub-module, module_sel_decoder:
  - Inputs addr_i and we_i.
  - Outputs the valid bit, index and one-hot write vector.
- The read mux lives in the top. It is an AND-OR of module data gated by the one-hot select.
- The side-band registers live in the top.
- No state machine.

## Test plan
- module_data_i = {FEEDC0DE, CAFEB0BA, 8BADF00D, DEADBEEF} (module 3..0), we_i=0, addr_i=0 -> data_o=0, module_we_o=0000, sel_valid_o=0.
- we_i=0, addr_i=1,2,3,4 -> data_o = DEADBEEF, 8BADF00D, CAFEB0BA, FEEDC0DE; module_we_o=0000 each time.
- we_i=1, addr_i=1,2,3,4 -> same data_o sequence; module_we_o = 0001, 0010, 0100, 1000.
- we_i=1, addr_i=0,5,6,7 -> data_o=0, module_we_o=0000; after an edge bad_wr_o=1.
  - bad_wr_o stays 1 through later valid writes and clears only after a wb_rst_i edge.
- Clocked: we_i=1 with addr_i=3, one edge -> last_sel_o=3.
  - we_i=0 with addr_i=2, one edge -> last_sel_o stays 3.
  - wb_rst_i=1 at the same edge as a valid write -> last_sel_o=0.
- Random sweep of addr_i, we_i and module data -> module_we_o is always one-hot or zero and matches the reference decode.
